// File: rtl/spi_led_pkg.sv
// Shared definitions for the LED-strip SPI stream transmitter: FSM state
// encodings and the strip's customary clock half-period.
package spi_led_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_LOW  = 2'b01;
  localparam state_t ST_HIGH = 2'b10;

  // Half-period (in spi_clk cycles) the LED strip is normally driven with.
  localparam int DEFAULT_HALF_PERIOD = 5;

endpackage : spi_led_pkg

// File: rtl/spi_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the SPI serialiser.
// rdata always shows the head entry; pop retires it. Pointers wrap modulo
// FIFO_DEPTH (a power of two), count tracks occupancy 0..FIFO_DEPTH.
module spi_tx_fifo
  import spi_led_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          spi_clk,
  input  logic                          spi_reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array is deliberately not reset; flushing the pointers
  // and count makes stale contents unreachable, and a resettable array would
  // turn cheap RAM into a bank of reset flops.
  always_ff @(posedge spi_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule : spi_tx_fifo

// File: rtl/spi_led_stream_tx.sv
// Streaming SPI transmitter for LED strips. Words arrive over valid/ready
// into a small FIFO and are shifted out back-to-back on spi_output_data /
// spi_output_clock with a runtime half-period, selectable bit order and
// selectable idle clock level. Data only changes when the clock returns to
// its idle level, so the slave samples on the active-going edge.
module spi_led_stream_tx
  import spi_led_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int HP_WIDTH   = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit CPOL       = 1'b0
) (
  input  logic                         spi_clk,
  input  logic                         spi_reset,
  input  logic [HP_WIDTH-1:0]          spi_half_period,
  input  logic [DATA_WIDTH-1:0]        spi_in_data,
  input  logic                         spi_in_valid,
  output logic                         spi_in_ready,
  output logic                         spi_output_data,
  output logic                         spi_output_clock,
  output logic                         spi_busy,
  output logic [$clog2(FIFO_DEPTH):0]  spi_fifo_level
);

  localparam int                 BIT_W      = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);
  localparam logic [HP_WIDTH-1:0] HP_ONE    = HP_WIDTH'(1);
  localparam logic               CLK_IDLE   = CPOL;
  localparam logic               CLK_ACTIVE = ~CPOL;

  // FIFO interface
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [DATA_WIDTH-1:0]       fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;

  // FSM and datapath registers with their next values
  state_t                state_q,   state_d;
  logic [HP_WIDTH-1:0]   hp_cnt_q,  hp_cnt_d;
  logic [HP_WIDTH-1:0]   h_q,       h_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic                  data_q,    data_d;
  logic                  sclk_q,    sclk_d;

  logic [HP_WIDTH-1:0]   h_eff;
  logic                  hp_done;
  logic                  bit_last;
  logic [DATA_WIDTH-1:0] shifted;

  // Bit presented first for a freshly loaded or freshly shifted word.
  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  spi_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .spi_clk   (spi_clk),
    .spi_reset (spi_reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .wdata     (spi_in_data),
    .rdata     (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A programmed half-period of zero behaves as one cycle.
  assign h_eff    = (spi_half_period == '0) ? HP_ONE : spi_half_period;
  assign hp_done  = (hp_cnt_q == (h_q - HP_ONE));
  assign bit_last = (bit_cnt_q == LAST_BIT);
  assign shifted  = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                              : {1'b0, shift_q[DATA_WIDTH-1:1]};

  assign spi_in_ready     = ~fifo_full;
  assign fifo_push        = spi_in_valid & spi_in_ready;
  assign spi_busy         = (state_q != ST_IDLE) | ~fifo_empty;
  assign spi_fifo_level   = fifo_count;
  assign spi_output_data  = data_q;
  assign spi_output_clock = sclk_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering; reset is sampled on the edge.
  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: idle until work is queued, then alternate LOW/HIGH.
  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOW;
      ST_LOW:  if (hp_done)     state_d = ST_HIGH;
      ST_HIGH: begin
        if (hp_done) begin
          state_d = (bit_last && fifo_empty) ? ST_IDLE : ST_LOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath decode: word loads, bit shifts, phase timing, pin levels.
  always_comb begin
    fifo_pop  = 1'b0;
    hp_cnt_d  = hp_cnt_q;
    h_d       = h_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    sclk_d    = sclk_q;
    case (state_q)
      ST_IDLE: begin
        data_d   = 1'b0;
        sclk_d   = CLK_IDLE;
        hp_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          data_d    = lead_bit(fifo_rdata);
          bit_cnt_d = '0;
          h_d       = h_eff;
        end
      end
      ST_LOW: begin
        if (hp_done) begin
          sclk_d   = CLK_ACTIVE;
          hp_cnt_d = '0;
        end else begin
          hp_cnt_d = hp_cnt_q + HP_ONE;
        end
      end
      ST_HIGH: begin
        if (hp_done) begin
          sclk_d   = CLK_IDLE;
          hp_cnt_d = '0;
          if (!bit_last) begin
            shift_d   = shifted;
            data_d    = lead_bit(shifted);
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end else if (!fifo_empty) begin
            // Chain straight into the next word with no idle cycle.
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            data_d    = lead_bit(fifo_rdata);
            bit_cnt_d = '0;
            h_d       = h_eff;
          end else begin
            data_d = 1'b0;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + HP_ONE;
        end
      end
      default: begin
        data_d    = 1'b0;
        sclk_d    = CLK_IDLE;
        hp_cnt_d  = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers; reset drops the pins to idle at once.
  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      hp_cnt_q  <= '0;
      h_q       <= HP_ONE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= 1'b0;
      sclk_q    <= CLK_IDLE;
    end else begin
      hp_cnt_q  <= hp_cnt_d;
      h_q       <= h_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule : spi_led_stream_tx

// File: tb/tb_spi_led_stream_tx.sv
// Directed bench for spi_led_stream_tx. Instance A: 8-bit, MSB first, CPOL=0.
// Instance B: 24-bit, LSB first, CPOL=1. Monitors rebuild words from the pins
// on the active-going clock edge and compare against a queue of pushed words.
module tb_spi_led_stream_tx;
  import spi_led_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A signals
  logic [15:0] a_hp;
  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_ready, a_sdo, a_sck, a_busy;
  logic [2:0]  a_level;

  // Instance B signals
  logic [15:0] b_hp;
  logic [23:0] b_data;
  logic        b_valid;
  logic        b_ready, b_sdo, b_sck, b_busy;
  logic [2:0]  b_level;

  spi_led_stream_tx #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .HP_WIDTH(16), .MSB_FIRST(1'b1), .CPOL(1'b0)
  ) u_dut_a (
    .spi_clk(clk), .spi_reset(rst), .spi_half_period(a_hp),
    .spi_in_data(a_data), .spi_in_valid(a_valid), .spi_in_ready(a_ready),
    .spi_output_data(a_sdo), .spi_output_clock(a_sck),
    .spi_busy(a_busy), .spi_fifo_level(a_level)
  );

  spi_led_stream_tx #(
    .DATA_WIDTH(24), .FIFO_DEPTH(4), .HP_WIDTH(16), .MSB_FIRST(1'b0), .CPOL(1'b1)
  ) u_dut_b (
    .spi_clk(clk), .spi_reset(rst), .spi_half_period(b_hp),
    .spi_in_data(b_data), .spi_in_valid(b_valid), .spi_in_ready(b_ready),
    .spi_output_data(b_sdo), .spi_output_clock(b_sck),
    .spi_busy(b_busy), .spi_fifo_level(b_level)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Scoreboards and pin observations
  logic [7:0]  a_exp_q[$];
  logic [23:0] b_exp_q[$];
  int          a_rise_q[$];
  int          a_hi_q[$];
  int          a_words = 0;
  int          b_words = 0;
  int          b_pulses = 0;
  int          a_last_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor A: sample on rising sck, MSB first; record rise times and high widths.
  initial begin : mon_a
    logic       prev;
    logic [7:0] sh;
    int         nbits;
    int         hi_run;
    prev = 1'b0; sh = '0; nbits = 0; hi_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0; nbits = 0; hi_run = 0;
      end else begin
        if (a_sck === 1'b1) hi_run++;
        if (a_sck === 1'b1 && prev === 1'b0) begin
          a_rise_q.push_back(cyc);
          sh = {sh[6:0], a_sdo};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            a_words++;
            check("a_sb_has_entry", a_exp_q.size() != 0, 1);
            if (a_exp_q.size() != 0) check("a_word", sh, a_exp_q.pop_front());
          end
        end
        if (a_sck === 1'b0 && prev === 1'b1) begin
          a_hi_q.push_back(hi_run);
          hi_run = 0;
        end
        prev = a_sck;
      end
    end
  end

  // Monitor B: sample on falling sck (CPOL=1), LSB first.
  initial begin : mon_b
    logic        prev;
    logic [23:0] sh;
    int          nbits;
    prev = 1'b1; sh = '0; nbits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1; nbits = 0;
      end else begin
        if (b_sck === 1'b0 && prev === 1'b1) begin
          b_pulses++;
          sh = {b_sdo, sh[23:1]};
          nbits++;
          if (nbits == 24) begin
            nbits = 0;
            b_words++;
            check("b_sb_has_entry", b_exp_q.size() != 0, 1);
            if (b_exp_q.size() != 0) check("b_word", sh, b_exp_q.pop_front());
          end
        end
        prev = b_sck;
      end
    end
  end

  // Offer a word to A and hold it until accepted; returns at the negedge after acceptance.
  task automatic push_a(input logic [7:0] w);
    int stall;
    stall = 0;
    a_valid = 1'b1;
    a_data  = w;
    while (!a_ready && stall < 400) begin
      @(negedge clk);
      stall++;
    end
    if (stall >= 400) check("push_a_timeout", a_ready, 1);
    a_last_stall = stall;
    a_exp_q.push_back(w);
    @(negedge clk);
  endtask

  task automatic push_b(input logic [23:0] w);
    int stall;
    stall = 0;
    b_valid = 1'b1;
    b_data  = w;
    while (!b_ready && stall < 400) begin
      @(negedge clk);
      stall++;
    end
    if (stall >= 400) check("push_b_timeout", b_ready, 1);
    b_exp_q.push_back(w);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int i;
    i = 0;
    while (a_busy !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, a_busy, 0);
  endtask

  task automatic clear_obs();
    a_rise_q.delete();
    a_hi_q.delete();
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    int         words0;
    int         stall_sum;

    rst = 1'b1;
    a_hp = 16'(DEFAULT_HALF_PERIOD); a_data = '0; a_valid = 1'b0;
    b_hp = 16'd2;                    b_data = '0; b_valid = 1'b0;
    repeat (3) @(negedge clk);

    // ---- Reset state
    check("rst_a_data", a_sdo, 0);
    check("rst_a_clock", a_sck, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_level", a_level, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_clock", b_sck, 1);
    check("rst_b_data", b_sdo, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Test 1: single word 0xA5, H=5
    clear_obs();
    pat = 8'hA5;
    push_a(pat);
    a_valid = 1'b0;
    check("t1_level_after_push", a_level, 1);
    @(negedge clk);                                 // after E0+1
    check("t1_level_after_pop", a_level, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_bit%0d", k), a_sdo, pat[7-k]);
      check($sformatf("t1_busy%0d", k), a_busy, 1);
      repeat (4) @(negedge clk);
      check($sformatf("t1_low%0d", k), a_sck, 0);
      @(negedge clk);
      check($sformatf("t1_high%0d", k), a_sck, 1);
      repeat (5) @(negedge clk);
    end
    // now after E0+81
    check("t1_busy_end", a_busy, 0);
    check("t1_data_end", a_sdo, 0);
    check("t1_clock_end", a_sck, 0);
    check("t1_sb_empty", a_exp_q.size(), 0);
    check("t1_pulses", a_hi_q.size(), 8);
    foreach (a_hi_q[i]) check($sformatf("t1_hi%0d", i), a_hi_q[i], 5);

    // ---- Test 2: back-to-back 0x81, 0xFF, 0x00
    repeat (3) @(negedge clk);
    clear_obs();
    words0 = a_words;
    stall_sum = 0;
    push_a(8'h81); stall_sum += a_last_stall;
    push_a(8'hFF); stall_sum += a_last_stall;
    push_a(8'h00); stall_sum += a_last_stall;
    a_valid = 1'b0;
    check("t2_level_peak", a_level, 2);
    check("t2_no_stall", stall_sum, 0);
    wait_idle_a("t2_idle", 600);
    check("t2_words", a_words - words0, 3);
    check("t2_sb_empty", a_exp_q.size(), 0);
    check("t2_rises", a_rise_q.size(), 24);
    for (int i = 1; i < a_rise_q.size(); i++)
      check($sformatf("t2_period%0d", i), a_rise_q[i] - a_rise_q[i-1], 10);

    // ---- Test 3: flood 6 words into a 4-deep FIFO
    repeat (3) @(negedge clk);
    clear_obs();
    words0 = a_words;
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    push_a(8'h55);
    check("t3_level_full", a_level, 4);
    check("t3_ready_low", a_ready, 0);
    push_a(8'h66);
    a_valid = 1'b0;
    check("t3_was_stalled", a_last_stall > 0, 1);
    wait_idle_a("t3_idle", 1200);
    check("t3_words", a_words - words0, 6);
    check("t3_sb_empty", a_exp_q.size(), 0);

    // ---- Test 4a: half-period 0 behaves as 1
    repeat (3) @(negedge clk);
    clear_obs();
    a_hp = 16'd0;
    push_a(8'h5A);
    a_valid = 1'b0;
    wait_idle_a("t4a_idle", 100);
    check("t4a_pulses", a_hi_q.size(), 8);
    foreach (a_hi_q[i]) check($sformatf("t4a_hi%0d", i), a_hi_q[i], 1);
    for (int i = 1; i < a_rise_q.size(); i++)
      check($sformatf("t4a_period%0d", i), a_rise_q[i] - a_rise_q[i-1], 2);

    // ---- Test 4b: H changes 5->2 mid-word; applies from the next word
    repeat (3) @(negedge clk);
    clear_obs();
    a_hp = 16'd5;
    push_a(8'h96);
    push_a(8'h69);
    a_valid = 1'b0;
    repeat (20) @(negedge clk);
    a_hp = 16'd2;
    wait_idle_a("t4b_idle", 400);
    check("t4b_pulses", a_hi_q.size(), 16);
    foreach (a_hi_q[i]) check($sformatf("t4b_hi%0d", i), a_hi_q[i], (i < 8) ? 5 : 2);
    check("t4b_sb_empty", a_exp_q.size(), 0);

    // ---- Test 5: reset during HIGH phase of bit 3
    repeat (3) @(negedge clk);
    a_hp = 16'd5;
    push_a(8'hC3);                                 // accepted at E0
    push_a(8'h99);                                 // accepted at E0+1, now after E0+1
    a_valid = 1'b0;
    check("t5_level_pre", a_level, 1);
    repeat (36) @(negedge clk);                    // after E0+37
    check("t5_in_high", a_sck, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_clock", a_sck, 0);
    check("t5_rst_data", a_sdo, 0);
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_level", a_level, 0);
    check("t5_rst_ready", a_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    a_exp_q.delete();
    clear_obs();
    words0 = a_words;
    @(negedge clk);
    push_a(8'h3C);
    a_valid = 1'b0;
    @(negedge clk);                                // after E0+1
    check("t5_first_bit", a_sdo, 0);
    wait_idle_a("t5_idle", 200);
    check("t5_words", a_words - words0, 1);
    check("t5_pulses", a_hi_q.size(), 8);
    check("t5_sb_empty", a_exp_q.size(), 0);

    // ---- Test 6: LSB first, CPOL=1, 24-bit word 0x000001, H=2
    repeat (3) @(negedge clk);
    push_b(24'h000001);                            // after E0
    @(negedge clk);                                // after E0+1
    check("t6_first_bit", b_sdo, 1);
    check("t6_clock_idle", b_sck, 1);
    repeat (2) @(negedge clk);                     // after E0+3
    check("t6_clock_active", b_sck, 0);
    repeat (2) @(negedge clk);                     // after E0+5
    check("t6_second_bit", b_sdo, 0);
    check("t6_clock_back", b_sck, 1);
    for (int i = 0; i < 200 && b_busy !== 1'b0; i++) @(negedge clk);
    check("t6_idle", b_busy, 0);
    check("t6_pulses", b_pulses, 24);
    check("t6_words", b_words, 1);
    check("t6_sb_empty", b_exp_q.size(), 0);
    check("t6_clock_rest", b_sck, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_spi_led_stream_tx
